// File: rtl/evr_trigger_conditioner_if.sv
//------------------------------------------------------------------------------
// Module : evr_trigger_conditioner_if
// Brief  : Trigger input/output and status bundle for evr_trigger_conditioner.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface evr_trigger_conditioner_if #(
    parameter int CNT_W = 16
);
    logic             evr_trigger;
    logic             enable;
    logic             trig_n;
    logic             trig_pulse;
    logic             busy;
    logic [CNT_W-1:0] trig_count;
    logic [CNT_W-1:0] reject_count;

    modport master (
        output evr_trigger, enable,
        input  trig_n, trig_pulse, busy, trig_count, reject_count
    );

    modport slave (
        input  evr_trigger, enable,
        output trig_n, trig_pulse, busy, trig_count, reject_count
    );
endinterface

`default_nettype wire

// File: rtl/evr_trigger_conditioner.sv
//------------------------------------------------------------------------------
// Module : evr_trigger_conditioner
// Brief  : Synchronises and deglitches the EVR trigger, emits a fixed-width
//          active-low pulse with holdoff, and counts accepted/rejected events.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module evr_trigger_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_WIDTH   = 50,
    parameter int OUT_WIDTH   = 600,
    parameter int HOLDOFF     = 10000,
    parameter int CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    evr_trigger_conditioner_if.slave  bus
);

    localparam int CMAX_A = (MIN_WIDTH > OUT_WIDTH) ? MIN_WIDTH : OUT_WIDTH;
    localparam int CMAX   = (CMAX_A > HOLDOFF) ? CMAX_A : HOLDOFF;
    localparam int CW     = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_QUALIFY   = 3'd1,
        S_FIRE      = 3'd2,
        S_WAIT_HIGH = 3'd3,
        S_HOLD      = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   vld_q;
    logic                   prev_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CNT_W-1:0]       trig_count_q, trig_count_d;
    logic [CNT_W-1:0]       reject_count_q, reject_count_d;
    logic                   trig_n_q;
    logic                   trig_pulse_q;
    logic                   s;
    logic                   fall_edge;

    assign s = sync_q[SYNC_STAGES-1];
    // vld_q masks the reset value of the sync chain so that a line already
    // low at reset release is not mistaken for a falling edge.
    assign fall_edge = vld_q[SYNC_STAGES] & prev_q & ~s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q         <= '1;
            vld_q          <= '0;
            prev_q         <= 1'b1;
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            trig_count_q   <= '0;
            reject_count_q <= '0;
            trig_n_q       <= 1'b1;
            trig_pulse_q   <= 1'b0;
        end else begin
            sync_q         <= {sync_q[SYNC_STAGES-2:0], bus.evr_trigger};
            vld_q          <= {vld_q[SYNC_STAGES-1:0], 1'b1};
            prev_q         <= s;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            trig_count_q   <= trig_count_d;
            reject_count_q <= reject_count_d;
            trig_n_q       <= (state_d != S_FIRE);
            trig_pulse_q   <= (state_d == S_FIRE) && (state_q != S_FIRE);
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        trig_count_d   = trig_count_q;
        reject_count_d = reject_count_q;
        unique case (state_q)
            S_IDLE: begin
                if (fall_edge && bus.enable) begin
                    state_d = S_QUALIFY;
                    cnt_d   = CW'(1);
                end
            end
            S_QUALIFY: begin
                if (!bus.enable) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CW'(MIN_WIDTH)) begin
                    state_d = S_FIRE;
                    cnt_d   = CW'(1);
                    if (trig_count_q != '1)
                        trig_count_d = trig_count_q + CNT_W'(1);
                end else if (s) begin
                    state_d = S_IDLE;
                    if (reject_count_q != '1)
                        reject_count_d = reject_count_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FIRE: begin
                if (cnt_q == CW'(OUT_WIDTH)) begin
                    state_d = s ? S_HOLD : S_WAIT_HIGH;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_HIGH: begin
                if (s) begin
                    state_d = S_HOLD;
                    cnt_d   = CW'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == CW'(HOLDOFF))
                    state_d = S_IDLE;
                else
                    cnt_d = cnt_q + CW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.trig_n       = trig_n_q;
    assign bus.trig_pulse   = trig_pulse_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.trig_count   = trig_count_q;
    assign bus.reject_count = reject_count_q;

endmodule

`default_nettype wire

// File: tb/tb_evr_trigger_conditioner.sv
//------------------------------------------------------------------------------
// Module : tb_evr_trigger_conditioner
// Brief  : Directed self-checking bench for evr_trigger_conditioner (defaults).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_evr_trigger_conditioner;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    evr_trigger_conditioner_if #(.CNT_W(16)) bus ();

    evr_trigger_conditioner #(
        .SYNC_STAGES(2),
        .MIN_WIDTH  (50),
        .OUT_WIDTH  (600),
        .HOLDOFF    (10000),
        .CNT_W      (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive a low pulse starting just before edge E0 (index 0); record the first
    // trig_n low index, first strobe index, total low cycles and strobe count.
    task automatic run_pulse(input int low_cycles, input int window,
                             output int fall_idx, output int pulse_idx,
                             output int low_n, output int pulses);
        fall_idx  = -1;
        pulse_idx = -1;
        low_n     = 0;
        pulses    = 0;
        bus.evr_trigger = 1'b0;
        for (int i = 0; i < window; i++) begin
            @(posedge clk);
            #1;
            if (i == low_cycles - 1)
                bus.evr_trigger = 1'b1;
            if (bus.trig_n == 1'b0) begin
                low_n++;
                if (fall_idx < 0) fall_idx = i;
            end
            if (bus.trig_pulse == 1'b1) begin
                pulses++;
                if (pulse_idx < 0) pulse_idx = i;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.evr_trigger = 1'b1;
        step(3);
        rst_n = 1'b1;
        step(10);
    endtask

    int fall, pidx, lown, npul;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.evr_trigger = 1'b1;
        bus.enable      = 1'b1;

        // 1: reset held with input toggling
        for (int i = 0; i < 12; i++) begin
            bus.evr_trigger = ~bus.evr_trigger;
            step(1);
        end
        chk("rst_trig_n",   32'(bus.trig_n),       32'd1);
        chk("rst_pulse",    32'(bus.trig_pulse),   32'd0);
        chk("rst_busy",     32'(bus.busy),         32'd0);
        chk("rst_trig_cnt", 32'(bus.trig_count),   32'd0);
        chk("rst_rej_cnt",  32'(bus.reject_count), 32'd0);
        bus.evr_trigger = 1'b1;
        rst_n = 1'b1;
        step(10);

        // 2: nominal 600-cycle pulse
        run_pulse(600, 700, fall, pidx, lown, npul);
        chk("t2_fall_latency", 32'(fall), 32'd52);
        chk("t2_pulse_idx",    32'(pidx), 32'd52);
        chk("t2_low_cycles",   32'(lown), 32'd600);
        chk("t2_pulses",       32'(npul), 32'd1);
        chk("t2_trig_cnt",     32'(bus.trig_count),   32'd1);
        chk("t2_rej_cnt",      32'(bus.reject_count), 32'd0);
        chk("t2_busy_hold",    32'(bus.busy),         32'd1);

        // 3: short glitch rejected, longer pulse accepted
        do_reset();
        run_pulse(30, 100, fall, pidx, lown, npul);
        chk("t3_glitch_fall", 32'(fall), 32'hFFFF_FFFF);
        chk("t3_glitch_rej",  32'(bus.reject_count), 32'd1);
        chk("t3_glitch_trig", 32'(bus.trig_count),   32'd0);
        chk("t3_glitch_busy", 32'(bus.busy),         32'd0);
        run_pulse(60, 100, fall, pidx, lown, npul);
        chk("t3_long_fall",   32'(fall), 32'd52);
        chk("t3_long_trig",   32'(bus.trig_count),   32'd1);
        chk("t3_long_rej",    32'(bus.reject_count), 32'd1);

        // 4: second pulse inside holdoff ignored, third accepted
        do_reset();
        run_pulse(600, 4500, fall, pidx, lown, npul);
        chk("t4_p1_fall", 32'(fall), 32'd52);
        run_pulse(600, 9000, fall, pidx, lown, npul);
        chk("t4_p2_fall", 32'(fall), 32'hFFFF_FFFF);
        chk("t4_p2_trig", 32'(bus.trig_count),   32'd1);
        chk("t4_p2_rej",  32'(bus.reject_count), 32'd0);
        run_pulse(600, 700, fall, pidx, lown, npul);
        chk("t4_p3_fall", 32'(fall), 32'd52);
        chk("t4_p3_trig", 32'(bus.trig_count),   32'd2);
        chk("t4_p3_rej",  32'(bus.reject_count), 32'd0);

        // 5: held-low input gives one pulse; holdoff counts from release
        do_reset();
        run_pulse(2000, 2100, fall, pidx, lown, npul);
        chk("t5_fall",   32'(fall), 32'd52);
        chk("t5_low",    32'(lown), 32'd600);
        chk("t5_pulses", 32'(npul), 32'd1);
        chk("t5_trig",   32'(bus.trig_count), 32'd1);
        step(9902);
        chk("t5_hold_last", 32'(bus.busy), 32'd1);
        step(1);
        chk("t5_hold_done", 32'(bus.busy), 32'd0);
        bus.enable = 1'b0;
        run_pulse(600, 700, fall, pidx, lown, npul);
        chk("t5_dis_fall", 32'(fall), 32'hFFFF_FFFF);
        chk("t5_dis_trig", 32'(bus.trig_count),   32'd1);
        chk("t5_dis_rej",  32'(bus.reject_count), 32'd0);
        bus.enable = 1'b1;

        // 6: asynchronous reset during FIRE with input held low
        do_reset();
        bus.evr_trigger = 1'b0;
        step(100);
        chk("t6_in_fire", 32'(bus.trig_n), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("t6_async_trig_n", 32'(bus.trig_n),     32'd1);
        chk("t6_async_busy",   32'(bus.busy),       32'd0);
        chk("t6_async_cnt",    32'(bus.trig_count), 32'd0);
        step(3);
        rst_n = 1'b1;
        lown = 0;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (bus.trig_n == 1'b0 || bus.busy == 1'b1) lown++;
        end
        chk("t6_no_rearm", 32'(lown), 32'd0);
        bus.evr_trigger = 1'b1;
        step(10);
        run_pulse(100, 200, fall, pidx, lown, npul);
        chk("t6_fall", 32'(fall), 32'd52);
        chk("t6_trig", 32'(bus.trig_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
